uart_tx_arbiter: RTL and testbench

- Shares the single board UART TX line between NREQ on-chip requesters, e.g. CPU store port, debug monitor and trace unit.
- Accepts one byte per grant using round-robin arbitration, then serializes it as an 8N1 frame at a fixed divider rate.
- Sits between the requesters and the top-level TX pin, which loops back to RX on the system bench.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 16 +
 rtl/uart_tx_core.sv | 88 ++++++++
 rtl/uart_tx_arbiter.sv | 75 +++++++
 tb/tb_uart_tx_arbiter.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbiter slice.
// Build option: define UART_PARITY_EN for 8E1 framing. Leave it undefined for 8N1.
package uart_pkg;

    localparam int   DATA_W      = 8;
    localparam int   DEF_CLK_DIV = 868;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side bus of the UART TX arbiter.
//   req_valid/req_data : per-requester byte offer; byte i is req_data[8i+7:8i]
//   req_ready          : one-cycle accept pulse, one-hot or zero
//   grant_id           : index of the last granted requester
//   master = requester side, slave = arbiter side
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]                  req_valid;
    logic [NREQ*uart_pkg::DATA_W-1:0] req_data;
    logic [NREQ-1:0]                  req_ready;
    logic [$clog2(NREQ)-1:0]          grant_id;

    modport master (output req_valid, req_data, input req_ready, grant_id);
    modport slave  (input req_valid, req_data, output req_ready, grant_id);
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: serializes one byte per load as a UART frame.
//   CLK, RST : clock, asynchronous active-low reset
//   load     : accepted only in IDLE; data_in is captured on the same edge
//   tx       : serial line, idle high
//   done     : high during the last cycle of STOP (IDLE is entered on the next edge)
//   UART_PARITY_EN : adds an even-parity bit after bit 7 (8E1)
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              done
);
    localparam int DW = $clog2(CLK_DIV);

    state_t            state;
    logic [DW-1:0]     div;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              wrap;
`ifdef UART_PARITY_EN
    logic              par;
`endif

    assign wrap = div == DW'(CLK_DIV - 1);
    assign done = state == STOP && wrap;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= IDLE_LEVEL;
`ifdef UART_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (load) begin
                state <= START;
                shift <= data_in;
                div   <= '0;
                tx    <= 1'b0;
`ifdef UART_PARITY_EN
                par   <= ^data_in;
`endif
            end
        end else begin
            div <= wrap ? '0 : div + 1'b1;
            if (wrap) begin
                case (state)
                    START: begin
                        state <= DATA;
                        tx    <= shift[0];
                        shift <= shift >> 1;
                    end
                    DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= IDLE_LEVEL;
`endif
                        end else begin
                            tx    <= shift[0];
                            shift <= shift >> 1;
                        end
                    end
`ifdef UART_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        tx    <= IDLE_LEVEL;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX line between NREQ requesters.
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : requester valid/data in, ready pulse and grant_id out
//   busy     : high while a frame is being shifted
//   TX       : serial line, idle high
//   UART_PARITY_EN : 8E1 framing instead of 8N1
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_arbiter_if.slave bus,
    output logic             busy,
    output logic             TX
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]     ptr;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     gid;
    logic [NREQ-1:0]   ready;
    logic [DATA_W-1:0] bytes [NREQ];
    logic              go;
    logic              done;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        return IW'((int'(a) + b) % NREQ);
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_byte
        assign bytes[i] = bus.req_data[DATA_W*i +: DATA_W];
    end

    // Scan from the far end back toward ptr so the nearest valid requester wins.
    always_comb begin
        winner = ptr;
        for (int j = NREQ - 1; j >= 0; j--)
            if (bus.req_valid[wrap_add(ptr, j)]) winner = wrap_add(ptr, j);
    end

    assign go = !busy && |bus.req_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr   <= '0;
            gid   <= '0;
            ready <= '0;
            busy  <= 1'b0;
        end else begin
            ready <= go ? NREQ'(1) << winner : '0;
            if (go) begin
                gid  <= winner;
                ptr  <= wrap_add(winner, 1);
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.grant_id  = gid;

    uart_tx_core #(.CLK_DIV(CLK_DIV)) u_core (
        .CLK     (CLK),
        .RST     (RST),
        .load    (go),
        .data_in (bytes[winner]),
        .tx      (TX),
        .done    (done)
    );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed, table-driven bench for uart_tx_arbiter (NREQ=4, CLK_DIV=4).
module tb_uart_tx_arbiter;
    localparam int CDIV = 4;
`ifdef UART_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          id;
        logic [7:0]  byt;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic busy, TX;
    int   nchecks = 0;
    int   nerr = 0;
    vec_t tab [11];

    uart_tx_arbiter_if #(.NREQ(4)) bus ();

    uart_tx_arbiter #(.NREQ(4), .CLK_DIV(CDIV)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .busy (busy),
        .TX   (TX)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one table entry, wait for its grant, then follow the whole frame on TX.
    task automatic run_vec(input int i);
        logic        got;
        logic [10:0] frame;
        logic [7:0]  rx;
        int          tx_err, busy_cnt;
        got = 1'b0;
        tx_err = 0;
        busy_cnt = 0;
        rx = '0;
        frame = {1'b1, tab[i].byt, 1'b0};
`ifdef UART_PARITY_EN
        frame = {1'b1, ^tab[i].byt, tab[i].byt, 1'b0};
`endif
        bus.req_valid = tab[i].valid;
        bus.req_data  = tab[i].data;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge CLK);
            got = |bus.req_ready;
        end
        check("grant_seen", 32'(got), 1);
        if (!got) return;
        check("ready_onehot", 32'(bus.req_ready), 32'(4'b1 << tab[i].id));
        check("grant_id", 32'(bus.grant_id), tab[i].id);
        for (int m = 0; m <= FL * CDIV; m++) begin
            if (m > 0) @(negedge CLK);
            if (m == 1) begin
                check("ready_pulse_len", 32'(bus.req_ready), 0);
                bus.req_valid = tab[i].valid & ~(4'b1 << tab[i].id);
            end
            if (m < FL * CDIV) begin
                if (TX !== frame[m / CDIV]) tx_err++;
                if (busy === 1'b1) busy_cnt++;
                if (m % CDIV == CDIV / 2 && m / CDIV >= 1 && m / CDIV <= 8) rx[m / CDIV - 1] = TX;
            end else begin
                check("idle_gap", 32'({TX, busy}), 32'(2'b10));
            end
        end
        check("tx_shape", tx_err, 0);
        check("rx_byte", 32'(rx), 32'(tab[i].byt));
        check("busy_len", busy_cnt, FL * CDIV);
    endtask

    initial begin
        tab[0]  = '{4'b0001, 32'h0000_0055, 0, 8'h55};
        tab[1]  = '{4'b0100, 32'h003C_0000, 2, 8'h3C};
        tab[2]  = '{4'b0110, 32'h0022_1100, 1, 8'h11};
        tab[3]  = '{4'b0100, 32'h0022_1100, 2, 8'h22};
        tab[4]  = '{4'b1000, 32'h0F00_0000, 3, 8'h0F};
        tab[5]  = '{4'b1111, 32'hA3A2_A1A0, 0, 8'hA0};
        tab[6]  = '{4'b1110, 32'hA3A2_A1A0, 1, 8'hA1};
        tab[7]  = '{4'b1100, 32'hA3A2_A1A0, 2, 8'hA2};
        tab[8]  = '{4'b1000, 32'hA3A2_A1A0, 3, 8'hA3};
        tab[9]  = '{4'b0010, 32'h0000_0700, 1, 8'h07};
        tab[10] = '{4'b0010, 32'h0000_0300, 1, 8'h03};
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (3) @(negedge CLK);
        check("reset_state", 32'({TX, busy, bus.req_ready, bus.grant_id}), 32'({1'b1, 1'b0, 4'b0, 2'b0}));
        RST = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            check("idle_state", 32'({TX, busy, bus.req_ready, bus.grant_id}), 32'({1'b1, 1'b0, 4'b0, 2'b0}));
        end
        for (int i = 0; i < 4; i++) run_vec(i);
        begin
            logic got;
            got = 1'b0;
            bus.req_valid = 4'b1000;
            bus.req_data  = 32'hFF00_0000;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge CLK);
                got = |bus.req_ready;
            end
            check("abort_grant", 32'({got, bus.grant_id}), 32'({1'b1, 2'd3}));
            @(negedge CLK);
            bus.req_valid = '0;
            repeat (19) @(negedge CLK);
            check("abort_busy", 32'(busy), 1);
            RST = 1'b0;
            #1;
            check("async_reset", 32'({TX, busy, bus.req_ready, bus.grant_id}), 32'({1'b1, 1'b0, 4'b0, 2'b0}));
            repeat (2) @(negedge CLK);
            RST = 1'b1;
            repeat (3) @(negedge CLK);
            check("post_reset_idle", 32'({TX, busy, bus.req_ready}), 32'({1'b1, 1'b0, 4'b0}));
        end
        for (int i = 4; i < 11; i++) run_vec(i);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
